// File: rtl/seq_checker.sv
// Receive-side checker for the mux-tree sequence generator: rebuilds the expected
// bit from in_bus and received-bit history, compares it, and tracks lock and errors.
module seq_checker #(
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 4,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_bus,
    input  logic             rx_bit,
    input  logic             rx_valid,
    input  logic             err_clr,
    output logic             exp_bit,
    output logic             chk_valid,
    output logic             mismatch,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [1:0] S_PRIME  = 2'd0;
    localparam logic [1:0] S_HUNT   = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    localparam logic [7:0] LOCK_TGT = 8'(LOCK_CNT);
    localparam logic [7:0] LOSS_TGT = 8'(LOSS_CNT);

    logic [1:0] state;
    logic [1:0] prime_cnt;
    logic [7:0] match_cnt;
    logic [7:0] miss_cnt;
    logic [7:0] prev_bus;
    logic [3:0] hist;          // hist[0]=r1 .. hist[3]=r4, newest first
    logic       exp_p0;
    logic       miss_p0;
    logic       vld_p0;

    // Mux tree: previous inputs pick first level, received history picks the rest.
    function automatic logic calc_exp(input logic [7:0] x, input logic [7:0] p,
                                      input logic [3:0] r);
        logic o1, o2, o3, o4, o5, o6, o7, o8;
        logic t1, t2, t3, t4, u1, u2;
        o1 = p[0] ? x[0] : x[4];
        o2 = p[1] ? x[0] : x[4];
        o3 = p[2] ? x[1] : x[5];
        o4 = p[3] ? x[1] : x[5];
        o5 = p[4] ? x[2] : x[6];
        o6 = p[5] ? x[2] : x[6];
        o7 = p[6] ? x[3] : x[7];
        o8 = p[7] ? x[3] : x[7];
        t1 = r[3] ? o1 : o2;
        t2 = r[3] ? o3 : o4;
        t3 = r[3] ? o5 : o6;
        t4 = r[3] ? o7 : o8;
        u1 = r[2] ? t1 : t2;
        u2 = r[2] ? t3 : t4;
        return r[1] ? u1 : u2;
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    assign vld_p0  = rx_valid;
    assign exp_p0  = calc_exp(in_bus, prev_bus, hist);
    assign miss_p0 = exp_p0 ^ rx_bit;

    // Stage p0 -> p1: history update, compare result and lock FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_PRIME;
            prime_cnt <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            prev_bus  <= '0;
            hist      <= '0;
            exp_bit   <= 1'b0;
            chk_valid <= 1'b0;
            mismatch  <= 1'b0;
            locked    <= 1'b0;
            err_count <= '0;
        end else begin
            chk_valid <= 1'b0;
            mismatch  <= 1'b0;
            if (vld_p0) begin
                prev_bus <= in_bus;
                hist     <= {hist[2:0], rx_bit};
                exp_bit  <= exp_p0;
                case (state)
                    S_PRIME: begin
                        if (prime_cnt == 2'd3) begin
                            state     <= S_HUNT;
                            prime_cnt <= '0;
                            match_cnt <= '0;
                            miss_cnt  <= '0;
                        end else begin
                            prime_cnt <= prime_cnt + 2'd1;
                        end
                    end
                    S_HUNT: begin
                        chk_valid <= 1'b1;
                        mismatch  <= miss_p0;
                        if (miss_p0) begin
                            match_cnt <= '0;
                        end else if (match_cnt + 8'd1 == LOCK_TGT) begin
                            state     <= S_LOCKED;
                            locked    <= 1'b1;
                            match_cnt <= '0;
                            miss_cnt  <= '0;
                        end else begin
                            match_cnt <= match_cnt + 8'd1;
                        end
                    end
                    S_LOCKED: begin
                        chk_valid <= 1'b1;
                        mismatch  <= miss_p0;
                        if (miss_p0) begin
                            err_count <= sat_inc(err_count);
                            if (miss_cnt + 8'd1 == LOSS_TGT) begin
                                state     <= S_HUNT;
                                locked    <= 1'b0;
                                match_cnt <= '0;
                                miss_cnt  <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + 8'd1;
                            end
                        end else begin
                            miss_cnt <= '0;
                        end
                    end
                    default: begin
                        state  <= S_PRIME;
                        locked <= 1'b0;
                    end
                endcase
            end
            // Clear takes priority over a same-cycle increment
            if (err_clr) err_count <= '0;
        end
    end

endmodule
